// File: rtl/vga_pkg.sv
// Shared timing constants for the scan-doubling line buffer scheduler.
package vga_pkg;
  localparam int VGA_HPERIOD  = 896;
  localparam int VGA_HALF     = VGA_HPERIOD / 2;
  localparam int VGA_RD_START = 80;
  localparam int VGA_RD_LEN   = 360;
  localparam int VGA_LINE_LEN = 360;
  localparam int VGA_ADDR_W   = 9;
endpackage

// File: rtl/vga_half_counter.sv
// TV line position counter with hsync resync; exposes the next-cycle
// half-line position so downstream registers line up with hcount.
module vga_half_counter
  import vga_pkg::*;
#(
  parameter int HPERIOD = VGA_HPERIOD,
  parameter int HCNT_W  = $clog2(HPERIOD),
  parameter int POS_W   = $clog2(HPERIOD / 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_start,
  output logic [POS_W-1:0] pos_nxt,
  output logic             half_nxt,
  output logic             line_start_nxt
);

  logic [HCNT_W-1:0] hcount;
  logic [HCNT_W-1:0] hcount_nxt;

  // A TV line start resyncs the count even when it lands mid-line.
  always_comb begin
    if (hsync_start) begin
      hcount_nxt = '0;
    end else if (hcount == HCNT_W'(HPERIOD - 1)) begin
      hcount_nxt = '0;
    end else begin
      hcount_nxt = hcount + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount <= '0;
    end else begin
      hcount <= hcount_nxt;
    end
  end

  assign half_nxt       = (hcount_nxt >= HCNT_W'(HPERIOD / 2));
  assign pos_nxt        = half_nxt ? POS_W'(hcount_nxt - HCNT_W'(HPERIOD / 2))
                                   : POS_W'(hcount_nxt);
  assign line_start_nxt = (pos_nxt == '0);

endmodule

// File: rtl/vga_line_sched.sv
// Ping-pong line buffer scheduler: TV-rate writer fills one bank while the
// VGA-rate reader plays the other bank back twice per TV line.
module vga_line_sched
  import vga_pkg::*;
#(
  parameter int HPERIOD  = VGA_HPERIOD,
  parameter int RD_START = VGA_RD_START,
  parameter int RD_LEN   = VGA_RD_LEN,
  parameter int LINE_LEN = VGA_LINE_LEN,
  parameter int ADDR_W   = VGA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync_start,
  input  logic              wr_stb,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_ovf,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_second,
  output logic              vga_line_start
);

  localparam int POS_W = $clog2(HPERIOD / 2);

  logic [POS_W-1:0] pos_nxt;
  logic             half_nxt;
  logic             line_start_nxt;
  logic             in_window;
  logic             addr_full;

  vga_half_counter #(
    .HPERIOD(HPERIOD)
  ) u_half_counter (
    .clk           (clk),
    .rst           (rst),
    .hsync_start   (hsync_start),
    .pos_nxt       (pos_nxt),
    .half_nxt      (half_nxt),
    .line_start_nxt(line_start_nxt)
  );

  assign in_window = (int'(pos_nxt) >= RD_START) && (int'(pos_nxt) < RD_START + RD_LEN);
  assign addr_full = (int'(wr_addr) >= LINE_LEN);

  // A strobe that coincides with the line start would land in the bank
  // being handed to the reader, so it is dropped outright.
  assign wr_en   = wr_stb & ~hsync_start & ~addr_full;
  assign rd_bank = ~wr_bank;

  // Read side: registered from next-cycle position, so zero latency vs hcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      rd_second      <= 1'b0;
      vga_line_start <= 1'b0;
    end else begin
      rd_en          <= in_window;
      rd_addr        <= in_window ? ADDR_W'(int'(pos_nxt) - RD_START) : '0;
      rd_second      <= half_nxt;
      vga_line_start <= line_start_nxt;
    end
  end

  // Write side: banks swap only on a real TV line start, never on free-run wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_addr <= '0;
      wr_ovf  <= 1'b0;
    end else if (hsync_start) begin
      wr_bank <= ~wr_bank;
      wr_addr <= '0;
      wr_ovf  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_addr <= wr_addr + 1'b1;
      end
      if (wr_stb && addr_full) begin
        wr_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_sched.sv
// Scoreboard bench for vga_line_sched: stimulus queues expected read, write
// and line-start events; a negedge monitor pops and compares them.
module tb_vga_line_sched;

  logic       clk;
  logic       rst;
  logic       hsync_start;
  logic       wr_stb;
  logic       wr_en;
  logic       wr_bank;
  logic [8:0] wr_addr;
  logic       wr_ovf;
  logic       rd_en;
  logic       rd_bank;
  logic [8:0] rd_addr;
  logic       rd_second;
  logic       vga_line_start;

  vga_line_sched dut (
    .clk           (clk),
    .rst           (rst),
    .hsync_start   (hsync_start),
    .wr_stb        (wr_stb),
    .wr_en         (wr_en),
    .wr_bank       (wr_bank),
    .wr_addr       (wr_addr),
    .wr_ovf        (wr_ovf),
    .rd_en         (rd_en),
    .rd_bank       (rd_bank),
    .rd_addr       (rd_addr),
    .rd_second     (rd_second),
    .vga_line_start(vga_line_start)
  );

  typedef struct {int cyc; logic bank; int addr; logic second;} rd_t;
  typedef struct {int cyc; logic second;} ls_t;
  typedef struct {int cyc; logic bank; int addr;} wr_t;

  rd_t rd_q[$];
  ls_t ls_q[$];
  wr_t wr_q[$];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic exp_wr_bank;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cyc %0d: got an event, expected none", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Expected reads/line starts for one TV period starting at edge 'base'.
  task automatic sched_line(input int base, input logic bank);
    ls_q.push_back('{base, 1'b0});
    for (int k = 0; k < 360; k++) rd_q.push_back('{base + 80 + k, bank, k, 1'b0});
    ls_q.push_back('{base + 448, 1'b1});
    for (int k = 0; k < 360; k++) rd_q.push_back('{base + 528 + k, bank, k, 1'b1});
  endtask

  task automatic flush(input int from);
    rd_t rt[$];
    ls_t lt[$];
    foreach (rd_q[i]) if (rd_q[i].cyc < from) rt.push_back(rd_q[i]);
    foreach (ls_q[i]) if (ls_q[i].cyc < from) lt.push_back(ls_q[i]);
    rd_q = rt;
    ls_q = lt;
  endtask

  task automatic pulse_hsync(input bit stb, output int base);
    hsync_start = 1'b1;
    if (stb) begin
      wr_stb = 1'b1;
      #1;
      chk("wr_en_on_hsync", int'(wr_en), 0);
    end
    base = cyc + 1;
    flush(base);
    exp_wr_bank = ~exp_wr_bank;
    sched_line(base, ~exp_wr_bank);
    tick();
    hsync_start = 1'b0;
    wr_stb      = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_wr_en"}, int'(wr_en), 0);
    chk({tag, "_wr_bank"}, int'(wr_bank), 0);
    chk({tag, "_rd_bank"}, int'(rd_bank), 1);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_ovf"}, int'(wr_ovf), 0);
    chk({tag, "_rd_en"}, int'(rd_en), 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_rd_second"}, int'(rd_second), 0);
    chk({tag, "_line_start"}, int'(vga_line_start), 0);
  endtask

  // Monitor: every presented event must match the head of its queue.
  always @(negedge clk) begin
    rd_t r;
    ls_t l;
    wr_t w;
    if (!rst) begin
      if (rd_en) begin
        if (rd_q.size() == 0) unexpected("rd_event");
        else begin
          r = rd_q.pop_front();
          chk("rd_cyc", cyc, r.cyc);
          chk("rd_bank", int'(rd_bank), int'(r.bank));
          chk("rd_addr", int'(rd_addr), r.addr);
          chk("rd_second", int'(rd_second), int'(r.second));
        end
      end
      if (vga_line_start) begin
        if (ls_q.size() == 0) unexpected("ls_event");
        else begin
          l = ls_q.pop_front();
          chk("ls_cyc", cyc, l.cyc);
          chk("ls_second", int'(rd_second), int'(l.second));
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) unexpected("wr_event");
        else begin
          w = wr_q.pop_front();
          chk("wr_cyc", cyc, w.cyc);
          chk("wr_bank", int'(wr_bank), int'(w.bank));
          chk("wr_addr", int'(wr_addr), w.addr);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog at cyc %0d: got no finish, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base1, base2, base3, base4;
    rst         = 1'b1;
    hsync_start = 1'b0;
    wr_stb      = 1'b0;
    exp_wr_bank = 1'b0;
    tick();
    tick();
    check_reset_state("rst0");
    rst = 1'b0;
    tick();
    tick();
    tick();

    // Line 1: normal line start, then 400 strobes overflowing the bank.
    pulse_hsync(1'b0, base1);
    chk("l1_wr_bank", int'(wr_bank), 1);
    chk("l1_rd_bank", int'(rd_bank), 0);
    chk("l1_line_start", int'(vga_line_start), 1);
    for (int i = 0; i < 400; i++) begin
      wr_stb = 1'b1;
      if (i < 360) wr_q.push_back('{cyc, 1'b1, i});
      tick();
    end
    wr_stb = 1'b0;
    chk("ovf_wr_addr", int'(wr_addr), 360);
    chk("ovf_flag", int'(wr_ovf), 1);
    wait_until(base1 + 895);

    // Line 2: strobe coincident with hsync is dropped; ovf/addr cleared.
    pulse_hsync(1'b1, base2);
    chk("l2_wr_addr", int'(wr_addr), 0);
    chk("l2_wr_ovf", int'(wr_ovf), 0);
    chk("l2_wr_bank", int'(wr_bank), 0);
    chk("l2_rd_bank", int'(rd_bank), 1);
    wr_stb = 1'b1;
    wr_q.push_back('{cyc, 1'b0, 0});
    tick();
    wr_stb = 1'b0;
    chk("l2_wr_addr_after", int'(wr_addr), 1);

    // Withhold hsync for two periods: same bank replays after each wrap.
    sched_line(base2 + 896, 1'b1);
    sched_line(base2 + 1792, 1'b1);
    wait_until(base2 + 896);
    chk("wrap_line_start", int'(vga_line_start), 1);
    chk("wrap_rd_bank", int'(rd_bank), 1);
    wait_until(base2 + 1792 + 500);
    chk("pre_abort_second", int'(rd_second), 1);

    // Early hsync in the second half aborts the reader.
    pulse_hsync(1'b0, base3);
    chk("abort_rd_en", int'(rd_en), 0);
    chk("abort_rd_addr", int'(rd_addr), 0);
    chk("abort_rd_second", int'(rd_second), 0);
    chk("abort_line_start", int'(vga_line_start), 1);
    chk("abort_wr_bank", int'(wr_bank), 1);
    chk("abort_rd_bank", int'(rd_bank), 0);

    // Asynchronous reset in the middle of a read window.
    wait_until(base3 + 300);
    chk("pre_rst_rd_en", int'(rd_en), 1);
    chk("pre_rst_rd_addr", int'(rd_addr), 220);
    rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    rd_q.delete();
    ls_q.delete();
    wr_q.delete();
    exp_wr_bank = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();

    // After release the first line behaves as from a clean start.
    pulse_hsync(1'b0, base4);
    chk("l4_wr_bank", int'(wr_bank), 1);
    chk("l4_rd_bank", int'(rd_bank), 0);
    wait_until(base4 + 895);

    chk("rd_q_drained", rd_q.size(), 0);
    chk("ls_q_drained", ls_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
